// File: rtl/filter_pkg.sv
// Shared definitions for the phase-detector decision filter: sample class
// encoding, default run length and the run-counter width helper.
package filter_pkg;

  // Classification of one sampled (in_p, in_n) pair.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } cls_e;

  // Default number of consecutive qualifying samples before a decision.
  localparam int FILTER_LEN_DEF = 4;

  // Bits needed to hold a run count of 0..len inclusive.
  function automatic int run_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/filter_run_counter.sv
// Run-length tracker for the decision filter. Remembers the class seen on the
// previous edge and counts how many consecutive edges carried the same
// non-NONE class, saturating at FILTER_LEN. The outputs describe the state
// that will be loaded on the coming edge, so the parent can register its
// decision in the same cycle as the count update.
module filter_run_counter
  import filter_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int CNT_W      = run_width(FILTER_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cls_i,
  output logic [CNT_W-1:0] run_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(FILTER_LEN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  cls_e             cls;
  cls_e             last_q, last_d;
  logic [CNT_W-1:0] run_q, run_d;

  assign cls = cls_e'(cls_i);

  // Next run length: NONE clears, a class change restarts at 1, a repeat
  // increments until the run reaches FILTER_LEN and then holds there.
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (cls == NONE) begin
      run_d  = '0;
      last_d = NONE;
    end else if (cls != last_q) begin
      run_d  = ONE_C;
      last_d = cls;
    end else if (run_q != LEN_C) begin
      run_d  = run_q + ONE_C;
    end
  end

  // Run length and previous class registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= '0;
      last_q <= NONE;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

  assign run_o = run_d;
  assign sat_o = (run_d == LEN_C);

endmodule

// File: rtl/filter.sv
// Decision filter for raw up/down phase-detector pulses. A decision is
// asserted only after FILTER_LEN consecutive edges sample the same class and
// drops as soon as the class changes.
// Build option: define FILTER_INPUT_SYNC_EN to pass in_p/in_n through a
// 2-flop synchronizer before classification (adds two cycles of latency);
// without it the inputs must already be synchronous to clk.
module filter
  import filter_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_p,
  input  logic in_n,
  output logic out_p,
  output logic out_n
);

  localparam int CNT_W = run_width(FILTER_LEN);

  logic [1:0]       raw;      // {p, n} as seen by the classifier
  cls_e             cls;
  logic [CNT_W-1:0] run;
  logic             sat;
  logic             out_p_q, out_p_d;
  logic             out_n_q, out_n_d;

  // Both-high and both-low are ambiguous and count as no indication.
  function automatic cls_e classify(input logic [1:0] pn);
    case (pn)
      2'b10:   return UP;
      2'b01:   return DN;
      default: return NONE;
    endcase
  endfunction

`ifdef FILTER_INPUT_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  // Two-stage synchronizer on both raw inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {in_p, in_n};
      sync2_q <= sync1_q;
    end
  end

  assign raw = sync2_q;
`else
  assign raw = {in_p, in_n};
`endif

  assign cls = classify(raw);

  filter_run_counter #(
    .FILTER_LEN (FILTER_LEN),
    .CNT_W      (CNT_W)
  ) u_run (
    .clk   (clk),
    .rst   (rst),
    .cls_i (cls),
    .run_o (run),
    .sat_o (sat)
  );

  // A decision holds only while the current class has filled the run; the
  // two classes are exclusive so at most one output can be set.
  always_comb begin
    out_p_d = 1'b0;
    out_n_d = 1'b0;
    if (sat) begin
      out_p_d = (cls == UP);
      out_n_d = (cls == DN);
    end
  end

  // Registered decision outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p_q <= 1'b0;
      out_n_q <= 1'b0;
    end else begin
      out_p_q <= out_p_d;
      out_n_q <= out_n_d;
    end
  end

  assign out_p = out_p_q;
  assign out_n = out_n_q;

  a_excl: assert property (@(posedge clk) !(out_p_q && out_n_q));
  a_sat:  assert property (@(posedge clk) disable iff (rst)
                           sat |-> (run == CNT_W'(FILTER_LEN)));

endmodule

// File: tb/tb_filter.sv
// Randomized and directed stimulus for the decision filter, checked by a
// scoreboard against a sliding-window reference model.
module tb_filter;
  import filter_pkg::*;

  localparam int LEN = 4;
`ifdef FILTER_INPUT_SYNC_EN
  localparam int SLAT = 2;
`else
  localparam int SLAT = 0;
`endif

  typedef struct packed {
    logic p;
    logic n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_p = 1'b0;
  logic in_n = 1'b0;
  logic out_p, out_n;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t expq[$];
  int   hist[$];          // classes sampled since reset, newest last
  logic [1:0] dline[$];   // raw pairs in flight through the synchronizer
  exp_t mon_e;

  always #5 clk = ~clk;

  filter #(.FILTER_LEN(LEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_p  (in_p),
    .in_n  (in_n),
    .out_p (out_p),
    .out_n (out_n)
  );

  // Reference: an output is set after an edge when the last LEN classified
  // samples since reset are all that output's class.
  task automatic model_edge(input logic p, input logic n, input logic r);
    logic [1:0] eff;
    int c, k;
    exp_t e;
    if (r) begin
      hist.delete();
      dline.delete();
      for (int i = 0; i < SLAT; i++) dline.push_back(2'b00);
      e.p = 1'b0;
      e.n = 1'b0;
      expq.push_back(e);
      return;
    end
    eff = {p, n};
    if (SLAT > 0) begin
      dline.push_back({p, n});
      eff = dline.pop_front();
    end
    c = (eff == 2'b10) ? 1 : (eff == 2'b01) ? 2 : 0;
    hist.push_back(c);
    if (hist.size() > LEN) void'(hist.pop_front());
    k = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != c) break;
      k++;
    end
    e.p = (c == 1) && (k >= LEN);
    e.n = (c == 2) && (k >= LEN);
    expq.push_back(e);
  endtask

  task automatic step(input logic p, input logic n, input logic r);
    @(negedge clk);
    in_p = p;
    in_n = n;
    rst  = r;
    @(posedge clk);
    model_edge(p, n, r);
  endtask

  task automatic hold(input logic p, input logic n, input int cnt);
    for (int i = 0; i < cnt; i++) step(p, n, 1'b0);
  endtask

  // Monitor: after every edge, compare the DUT against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        n_cmp++;
        if (out_p !== mon_e.p) begin
          n_bad++;
          $display("FAIL out_p t=%0t got=%b want=%b", $time, out_p, mon_e.p);
        end
        n_cmp++;
        if (out_n !== mon_e.n) begin
          n_bad++;
          $display("FAIL out_n t=%0t got=%b want=%b", $time, out_n, mon_e.n);
        end
        n_cmp++;
        if ((out_p & out_n) !== 1'b0) begin
          n_bad++;
          $display("FAIL excl t=%0t got=%b want=0", $time, out_p & out_n);
        end
      end
    end
  end

  initial begin
    int cls, len, wait_cyc;
    logic p, n;

    // Reset state
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // Sustained UP, then both high, then DN
    hold(1'b1, 1'b0, 6);
    hold(1'b1, 1'b1, 3);
    hold(1'b0, 1'b1, 6);

    // Short UP bursts separated by NONE never qualify
    for (int r = 0; r < 5; r++) begin
      hold(1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 1);
    end

    // Reset mid-run, then long UP run for saturation
    hold(1'b1, 1'b0, 3);
    step(1'b1, 1'b0, 1'b1);
    hold(1'b1, 1'b0, 300);

    // Direct reversal UP -> DN -> UP
    hold(1'b0, 1'b1, 5);
    hold(1'b1, 1'b0, 5);

    // Randomized segments with occasional reset
    for (int s = 0; s < 400; s++) begin
      cls = $urandom_range(0, 3);
      len = $urandom_range(1, 7);
      p = cls[1];
      n = cls[0];
      if ($urandom_range(0, 99) < 3) step(p, n, 1'b1);
      else hold(p, n, len);
    end
    hold(1'b0, 1'b0, 2);

    // Drain the scoreboard within a bounded number of cycles
    wait_cyc = 0;
    while (expq.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (expq.size() > 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending want=0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
